reg_file: RTL
=============

Name: reg_file

Overview:
- Integer register file for the single-cycle RISC-V core. It sits directly upstream of the ALU, driving srcA and srcB from rd1 and rd2, and directly downstream of it, receiving the ALU result on wd3 at writeback.
- Three read ports (two operand ports and one debug port) and one write port.
- After reset, a sequential clear sweep zeroes the array one register per cycle and then asserts ready. This lets the array map onto RAM without a parallel reset.

Parameters:
- XLEN, 32: data width.
- NREGS, 32: number of architectural registers. Address width AW = clog2(NREGS).
- BYPASS, 0: when 1, operand reads return the value being written in the same cycle.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- a1  in  AW  read address, port 1.
- a2  in  AW  read address, port 2.
- a3  in  AW  write address.
- we3  in  1  write enable.
- wd3  in  XLEN  write data (ALU result or load data).
- rd1  out  XLEN  read data, port 1 (feeds ALU srcA).
- rd2  out  XLEN  read data, port 2 (feeds ALU srcB mux).
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data.
- ready  out  1  high once the clear sweep is complete.
- wr_count  out  32  number of accepted writes.

Behaviour:
- States: CLEAR and RUN. The sweep counter clr_idx is AW bits wide.
- Reset: when reset=1 at a clk edge, the next state is CLEAR, clr_idx=1, ready=0 and wr_count=0. Reset asserted mid-sweep or while in RUN restarts the sweep from 1.
- CLEAR operation:
  - Each edge writes 0 to reg[clr_idx] and then increments clr_idx.
  - The edge that writes reg[NREGS-1] transitions the state to RUN and sets ready=1.
  - The sweep lasts NREGS-1 edges after reset deasserts (31 edges at the default).
  - x0 is never stored.
- During CLEAR:
  - rd1, rd2 and dbg_data are forced to 0.
  - we3 is ignored: no write occurs and wr_count is unchanged.
- RUN, reads:
  - Reads are combinational (asynchronous) with zero latency.
  - Address 0 always reads 0 on all three ports.
- RUN, writes:
  - A write is accepted on a rising edge when we3=1 and a3!=0. reg[a3] takes wd3 and wr_count increments.
  - wr_count wraps from 2^32-1 to 0.
  - we3=1 with a3=0 is discarded, and wr_count is not incremented.
- Same-cycle read/write of the same register:
  - BYPASS=0: the read returns the old value, and the new value is visible after the edge.
  - BYPASS=1: rd1 or rd2 returns wd3 when we3=1, a3==a(1|2), a3!=0 and ready=1.
  - dbg_data is never bypassed.
- Simultaneous events:
  - rd1 and rd2 may use the same address as each other.
  - reset has priority over a write in the same cycle; the write is dropped.
- Outputs at reset: ready=0, wr_count=0, rd1=rd2=dbg_data=0 (due to CLEAR forcing).
- No X may appear on any output after the first reset edge.

Decomposition:
- Shared package (core constants include):
  - XLEN=32.
  - REG_AW=5.
  - REG_X0=0.
  - Encoding of the reset states CLEAR=1'b0 and RUN=1'b1.
- Single module with no sub-module. The storage array is inferred inside reg_file, and the sweep counter and FSM sit in the same body.

Test Plan:
- Reset sweep: hold reset for 2 cycles, release, count edges → ready=0 for 31 edges, ready=1 on the 31st. dbg_addr=17 reads 0 throughout and after.
- Writeback path: after ready, a3=5, wd3=32'd15, we3=1 for one edge, then a1=5, a2=0 → rd1=15, rd2=0, wr_count=1. This mirrors ALU 10+5 feeding writeback.
- x0 protection: we3=1, a3=0, wd3=32'hDEADBEEF; then a1=0 → rd1=0, wr_count unchanged.
- Same-cycle hazard: reg6=32'd5. Write a3=6, wd3=32'd10 with a1=6 in the same cycle → rd1=5 before the edge with BYPASS=0, rd1=10 with BYPASS=1. After the edge, rd1=10 in both builds.
- Reset mid-operation:
  - Write reg9=32'hFFFF_FFFF in RUN.
  - Assert reset for 1 cycle.
  - Required: ready=0 immediately after that edge and wr_count=0.
  - Required: after 31 more edges, ready=1 and dbg_addr=9 reads 0.
  - Also re-assert reset 10 edges into a sweep → sweep restarts, and ready appears 31 edges after the final release.
- Writes during CLEAR: we3=1, a3=3, wd3=7 on sweep edge 2 → after ready, rd1 for a1=3 is 0 and wr_count=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and state encoding for the integer register file
package reg_file_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int REG_X0 = 0;
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;
endpackage

// File: rtl/reg_file.sv
// reg_file: 3-read/1-write integer register file with post-reset clear sweep
module reg_file
  import reg_file_pkg::*;
#(
  parameter int XLEN   = reg_file_pkg::XLEN,
  parameter int NREGS  = 1 << reg_file_pkg::REG_AW,
  parameter int BYPASS = 0,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic [AW-1:0]   a3,
  input  logic            we3,
  input  logic [XLEN-1:0] wd3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            ready,
  output logic [31:0]     wr_count
);
  localparam logic [AW-1:0] X0   = AW'(REG_X0);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [31:0]     wr_count_q, wr_count_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic            hit1, hit2;
  // next state: reset restarts the sweep, CLEAR zeroes one entry per edge, RUN accepts writes
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;
    mem_wa     = clr_idx_q;
    mem_wd     = '0;
    if (reset) begin
      state_d    = CLEAR;
      clr_idx_d  = AW'(1);
      wr_count_d = '0;
    end else if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      clr_idx_d = clr_idx_q + 1'b1;
      state_d   = (clr_idx_q == LAST) ? RUN : CLEAR;
    end else if (we3 && a3 != X0) begin
      mem_we     = 1'b1;
      mem_wa     = a3;
      mem_wd     = wd3;
      wr_count_d = wr_count_q + 32'd1;
    end
  end
  // control registers
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    clr_idx_q  <= clr_idx_d;
    wr_count_q <= wr_count_d;
  end
  // storage has no reset so it can map onto RAM; the sweep clears it instead
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end
  // asynchronous reads: zero while clearing or for x0, optional write-through on operand ports
  always_comb begin
    ready    = (state_q == RUN);
    wr_count = wr_count_q;
    hit1     = (BYPASS != 0) && we3 && a3 == a1 && a3 != X0 && ready;
    hit2     = (BYPASS != 0) && we3 && a3 == a2 && a3 != X0 && ready;
    rd1      = (!ready || a1 == X0) ? '0 : hit1 ? wd3 : mem_q[a1];
    rd2      = (!ready || a2 == X0) ? '0 : hit2 ? wd3 : mem_q[a2];
    dbg_data = (!ready || dbg_addr == X0) ? '0 : mem_q[dbg_addr];
  end
endmodule
